// File: rtl/gray_arb_pkg.sv
// Shared types and default sizing for the gray_conv_arbiter slice.
package gray_arb_pkg;

  localparam int unsigned GRAY_ARB_WIDTH = 32'd4;
  localparam int unsigned GRAY_ARB_NREQ  = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } gray_arb_state_t;

endpackage

// File: rtl/gray2bin_core.sv
// Purely combinational reflected-Gray to binary converter.
module gray2bin_core #(
  parameter int unsigned WIDTH = 32'd4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the running XOR of the Gray bits from the MSB down.
  always_comb begin
    bin_o = '0;
    bin_o[WIDTH-1] = gray_i[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary datapath between NREQ requesters.
// Optional adjacency checker enabled by defining GRAY_ARB_CHECK_EN (adds out_adj_err).
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_ARB_WIDTH,
  parameter int unsigned NREQ  = GRAY_ARB_NREQ,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id,
  input  logic                  out_ready
`ifdef GRAY_ARB_CHECK_EN
  ,
  output logic                  out_adj_err
`endif
);

  gray_arb_state_t  state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [WIDTH-1:0] gray_q;
  logic [IDW-1:0]   id_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_bin_q;
  logic [IDW-1:0]   out_id_q;

  logic [IDW:0]     pick_s;
  logic             grant_vld_s;
  logic [IDW-1:0]   grant_id_s;
  logic [WIDTH-1:0] grant_gray_s;
  logic [WIDTH-1:0] bin_s;

  // Returns {found, index} of the first valid requester at or after ptr, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0]   res;
    int unsigned    idx;
    logic [IDW-1:0] sel;
    res = '0;
    for (int unsigned k = 32'd0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      sel = idx[IDW-1:0];
      if (!res[IDW] && valid[sel]) begin
        res = {1'b1, sel};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Grant selection is only meaningful while idle.
  always_comb begin
    pick_s      = rr_pick(req_valid, rr_ptr_q);
    grant_id_s  = pick_s[IDW-1:0];
    grant_vld_s = (state_q == ST_IDLE) && pick_s[IDW];
  end

  // One-hot accept strobe and mux of the granted Gray word.
  always_comb begin
    req_ready    = '0;
    grant_gray_s = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == grant_id_s) begin
        grant_gray_s = req_gray[i*WIDTH +: WIDTH];
        req_ready[i] = grant_vld_s;
      end else begin
        grant_gray_s = grant_gray_s;
      end
    end
  end

  // Next search start: one past the requester just served, wrapping NREQ-1 to 0.
  always_comb begin
    if (id_q == IDW'(NREQ - 32'd1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = id_q + IDW'(1);
    end
  end

  gray2bin_core #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .gray_i (gray_q),
    .bin_o  (bin_s)
  );

  // Transaction FSM: capture in IDLE, convert in CONV, hold result until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gray_q      <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_s) begin
            gray_q  <= grant_gray_s;
            id_q    <= grant_id_s;
            state_q <= ST_CONV;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CONV: begin
          out_bin_q   <= bin_s;
          out_id_q    <= id_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= ST_IDLE;
          end else begin
            state_q     <= ST_HOLD;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_id    = out_id_q;

`ifdef GRAY_ARB_CHECK_EN
  logic [WIDTH-1:0] last_gray_q [NREQ];
  logic [NREQ-1:0]  seen_q;
  logic             out_adj_err_q;

  // Consecutive words from one Gray source must differ in exactly one bit.
  function automatic logic single_bit_diff(input logic [WIDTH-1:0] d);
    return (d != '0) && ((d & (d - WIDTH'(1))) == '0);
  endfunction

  // Per-requester history, flagged alongside the result and cleared with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        last_gray_q[i] <= '0;
      end
      seen_q        <= '0;
      out_adj_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CONV: begin
          out_adj_err_q     <= seen_q[id_q] && !single_bit_diff(gray_q ^ last_gray_q[id_q]);
          last_gray_q[id_q] <= gray_q;
          seen_q[id_q]      <= 1'b1;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_adj_err_q <= 1'b0;
          end else begin
            out_adj_err_q <= out_adj_err_q;
          end
        end
        default: begin
          out_adj_err_q <= out_adj_err_q;
        end
      endcase
    end
  end

  assign out_adj_err = out_adj_err_q;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed, scoreboard-based bench for gray_conv_arbiter (WIDTH=4, NREQ=4).
module tb_gray_conv_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_gray;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_bin;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;
`ifdef GRAY_ARB_CHECK_EN
  logic                  out_adj_err;
  logic                  last_adj_err;
`endif

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] bin;
  } exp_t;

  exp_t             sb_q[$];
  int               grant_log[$];
  int               tests = 0;
  int               fails = 0;
  logic [WIDTH-1:0] exp_tab [16];

  always #5 clk = ~clk;

  gray_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_gray   (req_gray),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_bin    (out_bin),
    .out_id     (out_id),
    .out_ready  (out_ready)
`ifdef GRAY_ARB_CHECK_EN
    ,
    .out_adj_err(out_adj_err)
`endif
  );

  // Reference conversion: bit i is the XOR of all Gray bits at positions >= i.
  function automatic logic [WIDTH-1:0] model_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    for (int i = 0; i < WIDTH; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on grant, pop and compare on result handshake.
  always @(negedge clk) begin
    int   gid;
    exp_t e;
    gid = 0;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        tests++;
        assert ($onehot(req_ready) && req_valid[gid]) else begin
          fails++;
          $error("FAIL grant_onehot: observed ready=%b valid=%b required one-hot on a valid req", req_ready, req_valid);
        end
        sb_q.push_back({gid[IDW-1:0], model_bin(req_gray[gid*WIDTH +: WIDTH])});
        grant_log.push_back(gid);
      end
      if (out_valid && out_ready) begin
        tests++;
        assert (sb_q.size() != 0) else begin
          fails++;
          $error("FAIL sb_unexpected: observed result id=%0d bin=%b required none", out_id, out_bin);
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          tests++;
          assert (out_bin === e.bin && out_id === e.id) else begin
            fails++;
            $error("FAIL sb_result: observed id=%0d bin=%b required id=%0d bin=%b", out_id, out_bin, e.id, e.bin);
          end
`ifdef GRAY_ARB_CHECK_EN
          last_adj_err = out_adj_err;
`endif
        end
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (sb_q.size() != 0 || out_valid); i++) cyc();
    chk("drain_empty", sb_q.size(), 0);
  endtask

  // One complete transaction on requester id with out_ready held high.
  task automatic xfer(input int id, input logic [WIDTH-1:0] g);
    cyc();
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_gray[id*WIDTH +: WIDTH] = g;
    out_ready = 1'b1;
    @(negedge clk);
    chk("xfer_ready", req_ready, 32'(1) << id);
    cyc();
    req_valid = '0;
    cyc();
    @(negedge clk);
    chk("xfer_valid", out_valid, 1);
    chk("xfer_bin", out_bin, exp_tab[g]);
    chk("xfer_id", out_id, id);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int b = 0; b < 16; b++) exp_tab[b ^ (b >> 1)] = b[WIDTH-1:0];
    rst_n     = 1'b0;
    req_valid = '0;
    req_gray  = '0;
    out_ready = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_req_ready", req_ready, 0);
    cyc();
    rst_n = 1'b1;

    // Test 1: single request, latency and value.
    cyc();
    req_valid = 4'b0001;
    req_gray[3:0] = 4'b1000;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("t1_ready_conv", req_ready, 0);
    chk("t1_valid_conv", out_valid, 0);
    cyc();
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_bin", out_bin, 4'b1111);
    chk("t1_id", out_id, 0);
    cyc();
    out_ready = 1'b1;
    drain();

    // Test 2: all four requesting after reset, served in order 0..3.
    do_reset();
    grant_log.delete();
    out_ready = 1'b1;
    cyc();
    req_gray  = {4'b0100, 4'b0101, 4'b0111, 4'b0110};
    req_valid = 4'b1111;
    repeat (12) cyc();
    req_valid = '0;
    drain();
    chk("t2_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_order", (grant_log.size() > i) ? grant_log[i] : -1, i);

    // Test 3: backpressure in HOLD, then next grant goes to id+1.
    out_ready = 1'b0;
    cyc();
    req_gray[7:4]  = 4'b1101;
    req_gray[11:8] = 4'b0011;
    req_valid = 4'b0110;
    @(negedge clk);
    chk("t3_ready1", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0100;
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_bin", out_bin, exp_tab[4'b1101]);
      chk("t3_hold_id", out_id, 1);
      chk("t3_hold_ready", req_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("t3_next_grant", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    drain();

    // Test 4: every Gray code through requester 2.
    for (int g = 0; g < 16; g++) begin
      xfer(2, g[WIDTH-1:0]);
      if (g == 10) chk("t4_1010", out_bin, 4'b1100);
      if (g == 9)  chk("t4_1001", out_bin, 4'b1110);
    end
    drain();

    // Test 5: reset during CONV drops the transaction and resets the pointer.
    cyc();
    req_gray[3:0] = 4'b0101;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t5_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_bin", out_bin, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    chk("t5_no_result", out_valid, 0);
    cyc();
    req_gray[15:12] = 4'b0110;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("t5_ptr_reset", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    cyc();
    @(negedge clk);
    chk("t5_bin", out_bin, exp_tab[4'b0101]);
    chk("t5_id", out_id, 0);
    drain();

`ifdef GRAY_ARB_CHECK_EN
    // Test 6: adjacency checker.
    do_reset();
    xfer(1, 4'b0011);
    chk("t6_first", last_adj_err, 0);
    xfer(1, 4'b0110);
    chk("t6_nonadj", last_adj_err, 1);
    do_reset();
    xfer(1, 4'b0011);
    chk("t6_first2", last_adj_err, 0);
    xfer(1, 4'b0010);
    chk("t6_adj", last_adj_err, 0);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
